// File: rtl/axis_frame_packer_if.sv
// AXI4-Stream bundle shared by the upstream (slave) and downstream (master)
// sides of the frame packer.
interface axis_frame_packer_if #(
    parameter int DATA_W = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic                  tlast;
    logic [DATA_W/8-1:0]   tkeep;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tkeep,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tkeep,
        output tready
    );
endinterface

// File: rtl/axis_frame_packer.sv
// Cuts a TLAST-less 32-bit stream into fixed-length frames, closing a partial
// frame early when the input stays idle for cfg_timeout_i cycles.
module axis_frame_packer #(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [LEN_W-1:0]     cfg_frame_len_i,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    axis_frame_packer_if.slave   s_axis,
    axis_frame_packer_if.master  m_axis,
    output logic                 frame_done_o,
    output logic                 timeout_flush_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 state_q;
    logic [DATA_W-1:0]      h_data_q;
    logic [LEN_W-1:0]       word_cnt_q;
    logic [LEN_W-1:0]       len_q;
    logic [TIMEOUT_W-1:0]   idle_cnt_q;
    logic                   o_valid_q;
    logic [DATA_W-1:0]      o_data_q;
    logic                   o_last_q;
    logic                   frame_done_q;
    logic                   timeout_flush_q;

    logic                   out_free_s;
    logic                   s_ready_s;
    logic                   accept_s;
    logic                   timeout_hit_s;
    logic [LEN_W-1:0]       len_d;
    logic [LEN_W-1:0]       word_cnt_d;

    // Handshake qualifiers and next-frame length derived from current registers.
    always_comb begin
        out_free_s    = !o_valid_q || m_axis.tready;
        s_ready_s     = aresetn && ((state_q == ST_EMPTY) || out_free_s);
        accept_s      = s_axis.tvalid && s_ready_s;
        len_d         = (cfg_frame_len_i == {LEN_W{1'b0}}) ? {{(LEN_W-1){1'b0}}, 1'b1}
                                                           : cfg_frame_len_i;
        word_cnt_d    = word_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
        timeout_hit_s = (cfg_timeout_i != {TIMEOUT_W{1'b0}}) &&
                        (idle_cnt_q == (cfg_timeout_i - {{(TIMEOUT_W-1){1'b0}}, 1'b1}));
    end

    // Frame FSM: hold register, output register, counters and status pulses.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q         <= ST_EMPTY;
            h_data_q        <= {DATA_W{1'b0}};
            word_cnt_q      <= {LEN_W{1'b0}};
            len_q           <= {{(LEN_W-1){1'b0}}, 1'b1};
            idle_cnt_q      <= {TIMEOUT_W{1'b0}};
            o_valid_q       <= 1'b0;
            o_data_q        <= {DATA_W{1'b0}};
            o_last_q        <= 1'b0;
            frame_done_q    <= 1'b0;
            timeout_flush_q <= 1'b0;
        end else begin
            frame_done_q    <= o_valid_q && m_axis.tready && o_last_q;
            timeout_flush_q <= 1'b0;
            // A consumed beat drops valid unless the FSM reloads O below.
            if (m_axis.tready) begin
                o_valid_q <= 1'b0;
            end
            case (state_q)
                ST_EMPTY: begin
                    idle_cnt_q <= {TIMEOUT_W{1'b0}};
                    if (accept_s) begin
                        h_data_q   <= s_axis.tdata;
                        word_cnt_q <= {{(LEN_W-1){1'b0}}, 1'b1};
                        len_q      <= len_d;
                        state_q    <= (len_d == {{(LEN_W-1){1'b0}}, 1'b1}) ? ST_FLUSH : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept_s) begin
                        o_valid_q  <= 1'b1;
                        o_data_q   <= h_data_q;
                        o_last_q   <= 1'b0;
                        h_data_q   <= s_axis.tdata;
                        word_cnt_q <= word_cnt_d;
                        idle_cnt_q <= {TIMEOUT_W{1'b0}};
                        state_q    <= (word_cnt_d == len_q) ? ST_FLUSH : ST_HOLD;
                    end else if (timeout_hit_s) begin
                        timeout_flush_q <= 1'b1;
                        idle_cnt_q      <= {TIMEOUT_W{1'b0}};
                        state_q         <= ST_FLUSH;
                    end else if (idle_cnt_q != {TIMEOUT_W{1'b1}}) begin
                        idle_cnt_q <= idle_cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FLUSH: begin
                    idle_cnt_q <= {TIMEOUT_W{1'b0}};
                    if (out_free_s) begin
                        o_valid_q <= 1'b1;
                        o_data_q  <= h_data_q;
                        o_last_q  <= 1'b1;
                        // Back-to-back: the incoming word opens the next frame.
                        if (accept_s) begin
                            h_data_q   <= s_axis.tdata;
                            word_cnt_q <= {{(LEN_W-1){1'b0}}, 1'b1};
                            len_q      <= len_d;
                            state_q    <= (len_d == {{(LEN_W-1){1'b0}}, 1'b1}) ? ST_FLUSH : ST_HOLD;
                        end else begin
                            word_cnt_q <= {LEN_W{1'b0}};
                            state_q    <= ST_EMPTY;
                        end
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    assign s_axis.tready   = s_ready_s;
    assign m_axis.tvalid   = o_valid_q;
    assign m_axis.tdata    = o_data_q;
    assign m_axis.tlast    = o_last_q;
    assign m_axis.tkeep    = {(DATA_W/8){1'b1}};
    assign frame_done_o    = frame_done_q;
    assign timeout_flush_o = timeout_flush_q;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Scoreboard bench for axis_frame_packer: directed stimulus pushes expected
// beats, an independent monitor pops and compares downstream handshakes.
module tb_axis_frame_packer;

    logic        aclk;
    logic        aresetn;
    logic [15:0] cfg_frame_len;
    logic [15:0] cfg_timeout;
    logic        frame_done;
    logic        timeout_flush;

    axis_frame_packer_if #(.DATA_W(32)) s_axis ();
    axis_frame_packer_if #(.DATA_W(32)) m_axis ();

    axis_frame_packer #(.DATA_W(32), .LEN_W(16), .TIMEOUT_W(16)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cfg_frame_len_i (cfg_frame_len),
        .cfg_timeout_i   (cfg_timeout),
        .s_axis          (s_axis),
        .m_axis          (m_axis),
        .frame_done_o    (frame_done),
        .timeout_flush_o (timeout_flush)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    int          fd_cnt  = 0;
    int          tf_cnt  = 0;
    int          rdy_mode = 0;
    logic [32:0] sb_q[$];

    logic        prev_v;
    logic        prev_r;
    logic [31:0] prev_d;
    logic        prev_l;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    // Downstream ready pattern: 0 always ready, 1 random, 2 stalled.
    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_axis.tready = 1'b1;
            1:       m_axis.tready = 1'($urandom_range(0, 1));
            default: m_axis.tready = 1'b0;
        endcase
    end

    // Monitor: scoreboard compare, stall stability, pulse counting.
    always @(negedge aclk) begin
        logic [32:0] e;
        if (!aresetn) begin
            prev_v = 1'b0;
        end else begin
            if (frame_done)    fd_cnt++;
            if (timeout_flush) tf_cnt++;
            if (prev_v && !prev_r) begin
                chk("stall_valid", 64'(m_axis.tvalid), 64'd1);
                chk("stall_data_last", {31'd0, m_axis.tlast, m_axis.tdata}, {31'd0, prev_l, prev_d});
            end
            if (m_axis.tvalid && m_axis.tready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", {31'd0, m_axis.tlast, m_axis.tdata}, 64'h1_FFFF_FFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat", {31'd0, m_axis.tlast, m_axis.tdata}, {31'd0, e});
                end
            end
            prev_v = m_axis.tvalid;
            prev_r = m_axis.tready;
            prev_d = m_axis.tdata;
            prev_l = m_axis.tlast;
        end
    end

    task automatic send(input logic [31:0] d, input bit last, input bit push);
        bit ok = 1'b0;
        int n = 0;
        if (push) sb_q.push_back({last, d});
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        while (!ok && n < 500) begin
            @(negedge aclk);
            ok = s_axis.tready;
            @(posedge aclk);
            #1;
            n++;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        s_axis.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    initial begin
        int n;
        bit got;
        aresetn       = 1'b0;
        cfg_frame_len = 16'd4;
        cfg_timeout   = 16'd0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = 32'd0;
        s_axis.tlast  = 1'b0;
        s_axis.tkeep  = 4'hF;
        m_axis.tready = 1'b1;
        prev_v        = 1'b0;
        prev_r        = 1'b0;
        prev_d        = 32'd0;
        prev_l        = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis.tdata), 64'd0);
        chk("rst_tlast", 64'(m_axis.tlast), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_timeout_flush", 64'(timeout_flush), 64'd0);
        chk("rst_s_tready", 64'(s_axis.tready), 64'd0);
        chk("rst_tkeep", 64'(m_axis.tkeep), 64'hF);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1: len 4, back-to-back 1..8
        for (int i = 1; i <= 8; i++) send(32'(i), (i % 4) == 0, 1'b1);
        drain();
        chk("t1_frame_done", 64'(fd_cnt), 64'd2);

        // 2: timeout 10 closes a 3-word frame; then a full frame 4..7
        cfg_timeout = 16'd10;
        for (int i = 1; i <= 3; i++) send(32'(i), i == 3, 1'b1);
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge aclk);
            n++;
            if (m_axis.tvalid && m_axis.tlast) got = 1'b1;
        end
        chk("t2_timeout_latency", 64'(n), 64'd12);
        drain();
        chk("t2_timeout_flush", 64'(tf_cnt), 64'd1);
        for (int i = 4; i <= 7; i++) send(32'(i), i == 7, 1'b1);
        drain();
        chk("t2_frame_done", 64'(fd_cnt), 64'd4);

        // 3: len 3, 30 words, random downstream ready
        cfg_timeout   = 16'd0;
        cfg_frame_len = 16'd3;
        rdy_mode      = 1;
        for (int i = 1; i <= 30; i++) send(32'h100 + 32'(i), (i % 3) == 0, 1'b1);
        drain();
        rdy_mode = 0;
        repeat (2) @(posedge aclk);
        #1;
        chk("t3_frame_done", 64'(fd_cnt), 64'd14);

        // 4: len 0 then len 1, every beat is a frame
        cfg_frame_len = 16'd0;
        for (int i = 1; i <= 5; i++) send(32'h200 + 32'(i), 1'b1, 1'b1);
        drain();
        cfg_frame_len = 16'd1;
        for (int i = 6; i <= 10; i++) send(32'h200 + 32'(i), 1'b1, 1'b1);
        drain();
        chk("t4_frame_done", 64'(fd_cnt), 64'd24);

        // 5: len 4, change to 2 after word 2 of the frame
        cfg_frame_len = 16'd4;
        send(32'h301, 1'b0, 1'b1);
        send(32'h302, 1'b0, 1'b1);
        cfg_frame_len = 16'd2;
        send(32'h303, 1'b0, 1'b1);
        send(32'h304, 1'b1, 1'b1);
        send(32'h305, 1'b0, 1'b1);
        send(32'h306, 1'b1, 1'b1);
        send(32'h307, 1'b0, 1'b1);
        send(32'h308, 1'b1, 1'b1);
        drain();
        chk("t5_frame_done", 64'(fd_cnt), 64'd27);

        // 6: len 8, partial frame stalled downstream, then reset
        cfg_frame_len = 16'd8;
        for (int i = 1; i <= 5; i++) send(32'h400 + 32'(i), 1'b0, i <= 4);
        drain();
        rdy_mode = 2;
        @(posedge aclk);
        #1;
        send(32'h406, 1'b0, 1'b0);
        @(negedge aclk);
        chk("t6_stalled_valid", 64'(m_axis.tvalid), 64'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("t6_reset_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("t6_reset_s_tready", 64'(s_axis.tready), 64'd0);
        aresetn  = 1'b1;
        rdy_mode = 0;
        @(posedge aclk);
        #1;
        for (int i = 1; i <= 8; i++) send(32'h500 + 32'(i), i == 8, 1'b1);
        drain();
        chk("t6_frame_done", 64'(fd_cnt), 64'd28);
        chk("final_timeout_flush", 64'(tf_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
